// File: rtl/counters_pkg.sv
// Shared constants for the counter family: mode encodings and default width.
package counters_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/v_counters_down_reload.sv
// Down counter with load, enable, stop and registered terminal-count pulse.
// Expiry either stops the counter (one-shot) or reloads the stored start value (periodic).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | not armed; q holds, en ignored, busy=0
// ST_RUN  | armed; counts down on en, expires at q=0 (busy=1)
module v_counters_down_reload
    import counters_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             c,
    input  logic             clr_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             mode,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] rld, rld_nxt;
    logic             tc_r, tc_nxt;

    always_ff @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rld   <= '0;
            tc_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rld   <= rld_nxt;
            tc_r  <= tc_nxt;
        end
    end

    // Load beats stop beats counting; a load on the expiry edge swallows that expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rld_nxt   = rld;
        tc_nxt    = 1'b0;
        if (load) begin
            cnt_nxt   = d;
            rld_nxt   = d;
            state_nxt = ST_RUN;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else if (state == ST_RUN && en) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - ONE;
            end else begin
                tc_nxt = 1'b1;
                if (mode == MODE_PERIODIC) begin
                    cnt_nxt = rld;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    assign q    = cnt;
    assign tc   = tc_r;
    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_v_counters_down_reload.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// stimulus, all compared every cycle against a behavioural model.
module tb_v_counters_down_reload;

    localparam int W = 4;

    logic         c = 1'b0;
    logic         clr_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // model state kept as plain integers
    int  m_q = 0;
    int  m_r = 0;
    bit  m_busy = 0;
    bit  m_tc = 0;

    v_counters_down_reload #(.WIDTH(W)) dut (
        .c(c), .clr_n(clr_n), .load(load), .d(d), .en(en),
        .mode(mode), .stop(stop), .q(q), .tc(tc), .busy(busy)
    );

    initial forever #5 c = ~c;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference
    always @(posedge c or negedge clr_n) begin
        if (!clr_n) begin
            m_q = 0; m_r = 0; m_busy = 0; m_tc = 0;
        end else if (load) begin
            m_q = int'(d); m_r = int'(d); m_busy = 1; m_tc = 0;
        end else if (stop) begin
            m_busy = 0; m_tc = 0;
        end else if (m_busy && en) begin
            if (m_q > 0) begin
                m_q = m_q - 1; m_tc = 0;
            end else begin
                m_tc = 1;
                if (mode) m_q = m_r;
                else m_busy = 0;
            end
        end else begin
            m_tc = 0;
        end
    end

    always @(negedge c) begin
        if (clr_n) begin
            chk("model_q", int'(q), m_q);
            chk("model_tc", int'(tc), int'(m_tc));
            chk("model_busy", int'(busy), int'(m_busy));
        end
    end

    task automatic tick();
        @(posedge c);
        #2;
    endtask

    task automatic do_load(input int val, input bit md);
        load = 1'b1; d = W'(val); mode = md;
        tick();
        load = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int pulses;
        int en_edges;
        bit seen;

        // reset and idle after release
        #23 clr_n = 1'b1;
        tick();
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc), 0);
        en = 1'b1;
        tick(); tick();
        chk("idle_after_rst", int'(busy), 0);

        // one-shot D=3
        do_load(3, 1'b0);
        chk("os_q0", int'(q), 3);
        chk("os_busy0", int'(busy), 1);
        tick(); chk("os_q1", int'(q), 2);
        tick(); chk("os_q2", int'(q), 1);
        tick(); chk("os_q3", int'(q), 0);
        chk("os_tc_early", int'(tc), 0);
        tick();
        chk("os_tc", int'(tc), 1);
        chk("os_busy_fall", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("os_hold_q", int'(q), 0);
            chk("os_hold_tc", int'(tc), 0);
        end

        // periodic D=2 over 12 cycles
        do_load(2, 1'b1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tc) pulses++;
        end
        chk("per_pulses", pulses, 4);
        chk("per_q_end", int'(q), 2);

        // enable gating D=4
        en = 1'b1;
        do_load(4, 1'b0);
        en_edges = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            en = (i % 2 == 0);
            tick();
            if (en) en_edges++;
            if (tc) begin
                seen = 1;
                chk("gate_tc_on_en", int'(en), 1);
            end
        end
        chk("gate_seen", int'(seen), 1);
        chk("gate_edges", en_edges, 5);

        // load on the expiry edge
        en = 1'b1;
        do_load(1, 1'b1);
        tick();
        chk("col_pre_q", int'(q), 0);
        do_load(7, 1'b1);
        chk("col_tc", int'(tc), 0);
        chk("col_q", int'(q), 7);

        // stop at Q=2
        do_load(5, 1'b0);
        tick(); tick(); tick();
        chk("stop_pre_q", int'(q), 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_q", int'(q), 2);
        tick(); tick();
        chk("stop_hold_q", int'(q), 2);

        // periodic D=0
        do_load(0, 1'b1);
        chk("z_tc_after_load", int'(tc), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("z_tc", int'(tc), 1);
        end

        // D=15 full period
        do_load(15, 1'b0);
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(); n++;
            if (tc) seen = 1;
        end
        chk("max_seen", int'(seen), 1);
        chk("max_period", n, 16);

        // async reset mid-count with Q=5
        en = 1'b0;
        do_load(5, 1'b0);
        chk("ar_pre_q", int'(q), 5);
        clr_n = 1'b0;
        #1;
        chk("ar_q", int'(q), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_tc", int'(tc), 0);
        load = 1'b1; d = 4'd3;
        tick();
        chk("ar_load_ign_q", int'(q), 0);
        chk("ar_load_ign_busy", int'(busy), 0);
        load = 1'b0;
        #1 clr_n = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom_range(0, 1));
            d    = W'($urandom_range(0, 15));
            tick();
        end
        load = 1'b0; stop = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/v_counters_down_reload.md
# v_counters_down_reload

Parameterised down counter with synchronous load, count enable and terminal-count (TC) detection. It is the counting-down counterpart of the team's up counters. Software or a controlling FSM writes a start value. The block counts toward zero, flags expiry with a one-cycle registered TC pulse, and then either stops (one-shot) or reloads the stored value and runs again (periodic). It sits beside the up-counter family and drives timeouts, prescalers and periodic ticks.

## Interface
- WIDTH, 4, counter and load-value width in bits (WIDTH ≥ 2)
- C  in  1  clock; all state updates on rising edge
- CLR_N  in  1  asynchronous active-low reset; one clock, async assert, no other reset
- LOAD  in  1  synchronous load strobe; captures D into counter and reload register, starts counting
- D  in  WIDTH  start/reload value, unsigned
- EN  in  1  count enable; when low, counter, TC and BUSY hold (TC forced low)
- MODE  in  1  0 = one-shot, 1 = periodic; sampled on every enabled expiry edge
- STOP  in  1  synchronous abort; clears BUSY, holds Q
- Q  out  WIDTH  current count value
- TC  out  1  registered terminal-count pulse
- BUSY  out  1  high while counting is armed

## Operation
- Internal state: count register (drives Q), reload register R (WIDTH bits), BUSY flag, TC flag.
- Two states, encoded by BUSY:
  - IDLE (BUSY=0): Q holds and EN is ignored.
  - RUN (BUSY=1).
- Per-edge priority, highest first:
  1. CLR_N low: Q=0, R=0, BUSY=0, TC=0, asynchronously.
  2. LOAD: Q←D, R←D, BUSY←1, TC←0.
  3. STOP: BUSY←0, TC←0, Q holds.
  4. RUN with EN=1 and Q≠0: Q←Q−1, TC←0.
  5. RUN with EN=1 and Q=0 (expiry): TC←1.
     - MODE=1: Q←R, stay in RUN.
     - MODE=0: BUSY←0, Q stays 0.
  6. Otherwise: Q, R and BUSY hold; TC←0.
- Arithmetic is unsigned modulo 2^WIDTH. Q=0 in RUN never decrements, so there is no wrap to all-ones.
- Period: a load of N gives TC after N+1 enabled cycles. D=0 in periodic mode with EN held high keeps TC high every cycle.
- D = 2^WIDTH−1 is legal and gives the maximum period of 2^WIDTH.
- LOAD while in RUN restarts the count from the new D and suppresses any expiry on that same edge.

## Timing
- All outputs are registered. No combinational path from any input to Q, TC or BUSY.
- LOAD sampled at edge k:
  - Q=D and BUSY=1 visible after edge k.
  - First decrement at the first EN=1 edge after k.
- TC is high for exactly the cycle following the expiry edge. It is never high in the cycle after a LOAD, a STOP or an EN=0 edge.
- One-shot expiry: BUSY falls on the same edge that raises TC.
- Reset is asynchronous. CLR_N low mid-count forces all outputs to 0 immediately, with no waiting for C. Release is synchronised externally, and the block assumes CLR_N deasserts away from the C edge.
- After reset release the block stays idle until LOAD.

## Structure
- Shared package `counters_pkg` holds:
  - MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1 constants
  - the default WIDTH constant, reused by the up-counter variants
- Single module with no sub-module. Count, reload and control fit one always block plus output assigns. Expected size is about 120–160 lines including comments.

## Test plan
- Reset: hold CLR_N=0 mid-count with Q=5 → Q=0, TC=0, BUSY=0 immediately (before the next C edge); LOAD ignored while CLR_N=0.
- One-shot: WIDTH=4, LOAD D=3, MODE=0, EN=1 → Q sequence 3,2,1,0. TC high for one cycle after the 4th enabled edge, BUSY low on that same edge, Q held at 0 for 10 further cycles.
- Periodic: LOAD D=2, MODE=1, EN=1 for 12 cycles → TC pulses every 3 cycles (4 pulses), Q cycles 2,1,0,2,1,0.
- Enable gating: LOAD D=4 with EN toggling 1,0,1,0 → Q decrements only on EN=1 edges. TC arrives after 5 enabled edges and never during EN=0.
- Collisions and boundaries:
  - LOAD D=7 on the expiry edge → no TC, Q=7.
  - STOP at Q=2 → BUSY=0, Q=2 held.
  - Periodic D=0 → TC continuously high.
  - D=15 (WIDTH=4) → TC after 16 edges.
